// File: rtl/hes_pkg.sv
// Shared types and constants for the HES control path.
package hes_pkg;

    typedef enum logic [2:0] {
        StAccept,
        StInit,
        StLoad,
        StRound,
        StFinLoad,
        StFinRound,
        StDone,
        StErr
    } hes_ctrl_state_t;

    localparam logic [31:0] H_INIT        = 32'h3FA1EF23;
    localparam int unsigned N_ROUNDS_DEF  = 8;
    localparam int unsigned LEN_BYTES_DEF = 8;
    localparam int unsigned R_I_W         = 3;

endpackage

// File: rtl/hes_round_counter.sv
// Wrapping index counter with synchronous clear; tc flags the last index.
module hes_round_counter
    import hes_pkg::*;
#(
    parameter int unsigned N_ROUNDS = N_ROUNDS_DEF
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [R_I_W-1:0] idx,
    output logic             tc
);

    localparam logic [R_I_W-1:0] LAST = R_I_W'(N_ROUNDS - 1);

    logic [R_I_W-1:0] idx_q, idx_d;

    assign tc  = (idx_q == LAST);
    assign idx = idx_q;

    always_comb begin
        idx_d = idx_q;
        if (clr) begin
            idx_d = '0;
        end else if (en) begin
            idx_d = tc ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/hes_control_unit.sv
// Sequences the HES datapath: per-byte load and rounds, then length-padding finalization.
module hes_control_unit
    import hes_pkg::*;
#(
    parameter int unsigned N_ROUNDS  = N_ROUNDS_DEF,
    parameter int unsigned LEN_BYTES = LEN_BYTES_DEF
) (
    input  logic             clock,
    input  logic             rst,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [7:0]       B,
    output logic             start,
    output logic             validate_input,
    output logic             switch_operation,
    output logic             validate_R_h,
    output logic [R_I_W-1:0] R_i,
    input  logic             case_R_c_zero,
    input  logic [31:0]      digest_in,
    output logic [31:0]      digest,
    output logic             digest_valid,
    output logic             err
);

    hes_ctrl_state_t state_q, state_d;
    logic             first_q, first_d;
    logic             last_q, last_d;
    logic [7:0]       byte_q, byte_d;
    logic [63:0]      len_q, len_d;
    logic [31:0]      digest_q, digest_d;
    logic [7:0]       b_q, b_d;
    logic             start_q, start_d;
    logic             vi_q, vi_d;
    logic             so_q, so_d;
    logic             vrh_q, vrh_d;
    logic [R_I_W-1:0] ri_q, ri_d;
    logic             dv_q, dv_d;
    logic             err_q, err_d;

    logic             rnd_clr, rnd_en, rnd_tc, fin_clr, fin_en, fin_tc;
    logic [R_I_W-1:0] rnd_idx, fin_idx, fin_sel;

    hes_round_counter #(.N_ROUNDS(N_ROUNDS)) u_rnd (
        .clock (clock),
        .rst   (rst),
        .clr   (rnd_clr),
        .en    (rnd_en),
        .idx   (rnd_idx),
        .tc    (rnd_tc)
    );

    hes_round_counter #(.N_ROUNDS(LEN_BYTES)) u_fin (
        .clock (clock),
        .rst   (rst),
        .clr   (fin_clr),
        .en    (fin_en),
        .idx   (fin_idx),
        .tc    (fin_tc)
    );

    always_comb begin
        state_d  = state_q;
        first_d  = first_q;
        last_d   = last_q;
        byte_d   = byte_q;
        len_d    = len_q;
        digest_d = digest_q;
        rnd_clr  = 1'b0;
        rnd_en   = 1'b0;
        fin_clr  = 1'b0;
        fin_en   = 1'b0;
        unique case (state_q)
            StAccept: begin
                if (in_valid) begin
                    byte_d  = in_data;
                    last_d  = in_last;
                    state_d = first_q ? StInit : StLoad;
                end
            end
            StInit: begin
                len_d   = '0;
                first_d = 1'b0;
                state_d = StLoad;
            end
            StLoad: begin
                if (!case_R_c_zero) begin
                    state_d = StErr;
                end else begin
                    len_d   = len_q + 64'd1;
                    rnd_clr = 1'b1;
                    state_d = StRound;
                end
            end
            StRound: begin
                rnd_en = 1'b1;
                if (rnd_tc) begin
                    fin_clr = last_q;
                    state_d = last_q ? StFinLoad : StAccept;
                end
            end
            StFinLoad: begin
                rnd_clr = 1'b1;
                state_d = StFinRound;
            end
            StFinRound: begin
                rnd_en = 1'b1;
                if (rnd_tc) begin
                    fin_en  = 1'b1;
                    state_d = fin_tc ? StDone : StFinLoad;
                end
            end
            StDone: begin
                digest_d = digest_in;
                first_d  = 1'b1;
                state_d  = StAccept;
            end
            StErr:   state_d = StErr;
            default: state_d = StAccept;
        endcase
    end

    // Outputs are registered, so decode them from the state being entered and the
    // counter values that state will see.
    assign fin_sel = (state_q == StFinRound) ? fin_idx + 1'b1 : '0;

    always_comb begin
        start_d = (state_d == StInit);
        vi_d    = (state_d inside {StLoad, StFinLoad});
        so_d    = (state_d inside {StFinLoad, StFinRound});
        vrh_d   = (state_d inside {StRound, StFinRound});
        ri_d    = '0;
        if (vrh_d && (state_q inside {StRound, StFinRound})) begin
            ri_d = rnd_idx + 1'b1;
        end
        b_d = 8'h00;
        unique case (state_d)
            StLoad, StRound: b_d = byte_d;
            StFinLoad:       b_d = len_q[{fin_sel, 3'b000} +: 8];
            StFinRound:      b_d = b_q;
            default:         b_d = 8'h00;
        endcase
        dv_d  = (state_q == StDone);
        err_d = (state_d == StErr);
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q  <= StAccept;
            first_q  <= 1'b1;
            last_q   <= 1'b0;
            byte_q   <= 8'h00;
            len_q    <= '0;
            digest_q <= '0;
            b_q      <= 8'h00;
            start_q  <= 1'b0;
            vi_q     <= 1'b0;
            so_q     <= 1'b0;
            vrh_q    <= 1'b0;
            ri_q     <= '0;
            dv_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            first_q  <= first_d;
            last_q   <= last_d;
            byte_q   <= byte_d;
            len_q    <= len_d;
            digest_q <= digest_d;
            b_q      <= b_d;
            start_q  <= start_d;
            vi_q     <= vi_d;
            so_q     <= so_d;
            vrh_q    <= vrh_d;
            ri_q     <= ri_d;
            dv_q     <= dv_d;
            err_q    <= err_d;
        end
    end

    assign in_ready         = (state_q == StAccept);
    // A saturated counter seen in LOAD must not let the byte reach the datapath.
    assign validate_input   = vi_q & (so_q | case_R_c_zero);
    assign switch_operation = so_q;
    assign validate_R_h     = vrh_q;
    assign R_i              = ri_q;
    assign B                = b_q;
    assign start            = start_q;
    assign digest           = digest_q;
    assign digest_valid     = dv_q;
    assign err              = err_q;

endmodule

// File: tb/tb_hes_control_unit.sv
// Self-checking bench for hes_control_unit: directed table, corner sequences, random traces.
module tb_hes_control_unit;

    localparam int NR = 8;
    localparam int LB = 8;

    logic        clock = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic [7:0]  B;
    logic        start, validate_input, switch_operation, validate_R_h;
    logic [2:0]  R_i;
    logic        case_R_c_zero = 1'b1;
    logic [31:0] digest_in = 32'h0;
    logic [31:0] digest;
    logic        digest_valid, err;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    hes_control_unit #(.N_ROUNDS(NR), .LEN_BYTES(LB)) dut (
        .clock            (clock),
        .rst              (rst),
        .in_data          (in_data),
        .in_valid         (in_valid),
        .in_last          (in_last),
        .in_ready         (in_ready),
        .B                (B),
        .start            (start),
        .validate_input   (validate_input),
        .switch_operation (switch_operation),
        .validate_R_h     (validate_R_h),
        .R_i              (R_i),
        .case_R_c_zero    (case_R_c_zero),
        .digest_in        (digest_in),
        .digest           (digest),
        .digest_valid     (digest_valid),
        .err              (err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".in_ready"}, in_ready, 1);
        chk({tag, ".start"}, start, 0);
        chk({tag, ".vi"}, validate_input, 0);
        chk({tag, ".so"}, switch_operation, 0);
        chk({tag, ".vrh"}, validate_R_h, 0);
        chk({tag, ".R_i"}, R_i, 0);
        chk({tag, ".B"}, B, 0);
        chk({tag, ".digest"}, digest, 0);
        chk({tag, ".dv"}, digest_valid, 0);
        chk({tag, ".err"}, err, 0);
    endtask

    task automatic do_reset(input string tag);
        @(posedge clock); #1;
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00; case_R_c_zero = 1'b1;
        @(posedge clock); #1;
        rst = 1'b0;
        @(negedge clock);
        chk_reset(tag);
    endtask

    // Directed messages: inputs plus expected cycles relative to the first presented byte.
    typedef struct {
        int       n;
        bit [7:0] d0, d1, d2;
        int       h0, h1, h2;
        int       st;
        bit [7:0] fin0;
        int       fin_cyc;
        int       dv_cyc;
    } row_t;

    task automatic run_row(input row_t r, input string tag);
        int hs_got[3];
        int k = 0, st = -1, dv = -1, nfin = 0;
        bit [31:0] dig = 0;
        hs_got = '{-1, -1, -1};
        for (int c = 0; c < 300 && dv < 0; c++) begin
            @(posedge clock); #1;
            in_valid  = (k < r.n);
            in_data   = (k == 0) ? r.d0 : (k == 1) ? r.d1 : r.d2;
            in_last   = (k == r.n - 1);
            digest_in = 32'hD1670000 ^ c;
            @(negedge clock);
            if (in_valid && in_ready) begin
                hs_got[k] = c;
                k++;
            end
            if (start && st < 0) st = c;
            if (switch_operation && validate_input) begin
                chk({tag, ".fin_cycle"}, c, r.fin_cyc + (NR + 1) * nfin);
                chk({tag, ".fin_byte"}, B, (nfin == 0) ? r.fin0 : 8'h00);
                nfin++;
            end
            if (digest_valid) begin
                dv  = c;
                dig = digest;
            end
        end
        in_valid = 1'b0;
        chk({tag, ".start_cycle"}, st, r.st);
        chk({tag, ".hs0"}, hs_got[0], r.h0);
        if (r.n > 1) chk({tag, ".hs1"}, hs_got[1], r.h1);
        if (r.n > 2) chk({tag, ".hs2"}, hs_got[2], r.h2);
        chk({tag, ".fin_count"}, nfin, LB);
        chk({tag, ".dv_cycle"}, dv, r.dv_cyc);
        chk({tag, ".digest"}, dig, 32'hD1670000 ^ (r.dv_cyc - 1));
    endtask

    // Reference trace: one record per cycle of what to drive and what to expect.
    typedef struct {
        bit        rdy, hv, lst;
        bit [7:0]  data;
        bit        st, vi, so, vrh;
        bit [2:0]  ri;
        bit [7:0]  b;
        bit        chkb, dv;
        bit [31:0] dig, din;
    } cyc_t;

    cyc_t      q[$];
    bit        pend_dv = 0;
    bit [31:0] cur_dig = 0;

    function automatic cyc_t blank();
        cyc_t e;
        e = '{default: 0};
        e.chkb = 1'b1;
        return e;
    endfunction

    task automatic push(input cyc_t e);
        e.dv    = pend_dv;
        pend_dv = 1'b0;
        e.dig   = cur_dig;
        e.din   = $urandom;
        q.push_back(e);
    endtask

    task automatic gen_msg(input int n);
        longint unsigned len = 0;
        cyc_t e;
        bit [7:0] mb;
        for (int i = 0; i < n; i++) begin
            mb = 8'($urandom);
            repeat ($urandom_range(0, 2)) begin
                e = blank(); e.rdy = 1; push(e);
            end
            e = blank(); e.rdy = 1; e.hv = 1; e.data = mb; e.lst = (i == n - 1); push(e);
            if (i == 0) begin
                e = blank(); e.st = 1; push(e);
            end
            len++;
            e = blank(); e.vi = 1; e.b = mb; push(e);
            for (int r = 0; r < NR; r++) begin
                e = blank(); e.vrh = 1; e.ri = 3'(r); e.b = mb; push(e);
            end
        end
        for (int k = 0; k < LB; k++) begin
            e = blank(); e.so = 1; e.vi = 1; e.b = 8'(len >> (8 * k)); push(e);
            for (int r = 0; r < NR; r++) begin
                e = blank(); e.so = 1; e.vrh = 1; e.ri = 3'(r); e.chkb = 0; push(e);
            end
        end
        e = blank(); push(e);
        cur_dig = q[$].din;
        pend_dv = 1'b1;
    endtask

    task automatic run_trace();
        foreach (q[i]) begin
            @(posedge clock); #1;
            in_valid  = q[i].rdy ? q[i].hv : 1'($urandom_range(0, 1));
            in_data   = q[i].rdy ? q[i].data : 8'($urandom);
            in_last   = q[i].rdy ? q[i].lst : 1'($urandom);
            digest_in = q[i].din;
            @(negedge clock);
            chk("rnd.in_ready", in_ready, q[i].rdy);
            chk("rnd.start", start, q[i].st);
            chk("rnd.vi", validate_input, q[i].vi);
            chk("rnd.so", switch_operation, q[i].so);
            chk("rnd.vrh", validate_R_h, q[i].vrh);
            chk("rnd.R_i", R_i, q[i].ri);
            if (q[i].chkb) chk("rnd.B", B, q[i].b);
            chk("rnd.dv", digest_valid, q[i].dv);
            chk("rnd.digest", digest, q[i].dig);
            chk("rnd.err", err, 0);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        row_t rows[4];
        int   hs2;
        int   bad;
        rows[0] = '{n: 1, d0: 8'hA5, d1: 8'h00, d2: 8'h00, h0: 0, h1: 0, h2: 0,
                    st: 1, fin0: 8'h01, fin_cyc: 11, dv_cyc: 84};
        rows[1] = '{n: 3, d0: 8'h00, d1: 8'hFF, d2: 8'h3C, h0: 0, h1: 11, h2: 21,
                    st: 1, fin0: 8'h03, fin_cyc: 31, dv_cyc: 104};
        rows[2] = '{n: 1, d0: 8'h5A, d1: 8'h00, d2: 8'h00, h0: 0, h1: 0, h2: 0,
                    st: 1, fin0: 8'h01, fin_cyc: 11, dv_cyc: 84};
        rows[3] = '{n: 2, d0: 8'h12, d1: 8'h34, d2: 8'h00, h0: 0, h1: 11, h2: 0,
                    st: 1, fin0: 8'h02, fin_cyc: 21, dv_cyc: 94};

        do_reset("reset");
        for (int i = 0; i < 4; i++) run_row(rows[i], $sformatf("row%0d", i));

        // Reset during a finalization round aborts the message.
        for (int c = 0; c <= 40; c++) begin
            @(posedge clock); #1;
            in_valid = (c == 0); in_data = 8'hA5; in_last = 1'b1; rst = (c == 40);
            @(negedge clock);
            if (c == 40) begin
                chk("abort.so_at_40", switch_operation, 1);
                chk("abort.vrh_at_40", validate_R_h, 1);
            end
        end
        @(posedge clock); #1;
        rst = 1'b0;
        @(negedge clock);
        chk_reset("abort");
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clock);
            if (digest_valid || start) bad++;
        end
        chk("abort.no_dv_or_start", bad, 0);
        run_row(rows[0], "after_abort");

        // in_valid during rounds is ignored until the next ACCEPT cycle.
        do_reset("reset2");
        hs2 = -1;
        for (int c = 0; c <= 12; c++) begin
            @(posedge clock); #1;
            in_valid = (c == 0) || (c >= 5);
            in_data  = (c == 0) ? 8'h11 : 8'h22;
            in_last  = (c != 0);
            @(negedge clock);
            if (c > 0 && in_valid && in_ready && hs2 < 0) hs2 = c;
            if (c == 10) begin
                chk("busy.B_held", B, 8'h11);
                chk("busy.R_i_last", R_i, 7);
            end
            if (c == 12) begin
                chk("busy.load_vi", validate_input, 1);
                chk("busy.load_B", B, 8'h22);
            end
        end
        chk("busy.hs_cycle", hs2, 11);

        // Saturated counter at LOAD locks into ERR until reset.
        do_reset("reset3");
        for (int c = 0; c <= 10; c++) begin
            @(posedge clock); #1;
            in_valid = 1'b1; in_data = 8'h5C; in_last = 1'b1; case_R_c_zero = 1'b0;
            @(negedge clock);
            if (c == 2) chk("err.load_vi", validate_input, 0);
            if (c >= 3) begin
                chk("err.err", err, 1);
                chk("err.in_ready", in_ready, 0);
                chk("err.vi", validate_input, 0);
                chk("err.vrh", validate_R_h, 0);
                chk("err.start", start, 0);
                chk("err.B", B, 0);
            end
        end
        do_reset("err_clear");

        // Randomized messages against the reference trace.
        q.delete();
        cur_dig = 32'h0;
        pend_dv = 1'b0;
        for (int m = 0; m < 6; m++) gen_msg($urandom_range(1, 4));
        begin
            cyc_t e;
            e = blank(); e.rdy = 1; push(e);
        end
        run_trace();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hes_control_unit.md
# hes_control_unit

Control unit sitting directly upstream of `Operative_module`: accepts the message byte stream over a valid/ready handshake and sequences the datapath's `start`, `validate_input`, `switch_operation`, `validate_R_h` and `R_i` strobes. It runs 8 S-box/xor-shift rounds per byte and a length-padding finalization over the 64-bit byte count. It returns the 32-bit digest with a one-cycle valid strobe.

## Interface
Parameters:
- `N_ROUNDS`, 8, rounds per byte; drives `R_i` 0..N_ROUNDS-1; legal range 1..8.
- `LEN_BYTES`, 8, finalization bytes (message length, LSB first); legal range 1..8.

Ports (one clock; reset is synchronous and active-high):
- `clock`  in  1  rising-edge clock.
- `rst`  in  1  synchronous active-high reset.
- `in_data`  in  8  message byte.
- `in_valid`  in  1  `in_data` valid.
- `in_last`  in  1  final byte of message; qualified by `in_valid`.
- `in_ready`  out  1  byte accepted on `in_valid & in_ready`.
- `B`  out  8  byte to datapath.
- `start`  out  1  datapath re-init pulse: R_c=0, R_h=H_INIT.
- `validate_input`  out  1  datapath loads `B`.
- `switch_operation`  out  1  high during finalization; datapath must not increment R_c.
- `validate_R_h`  out  1  datapath commits xor-shift result.
- `R_i`  out  3  round index.
- `case_R_c_zero`  in  1  datapath counter not saturated.
- `digest_in`  in  32  datapath R_h.
- `digest`  out  32  captured digest.
- `digest_valid`  out  1  one-cycle strobe.
- `err`  out  1  sticky length-overflow flag.

## Operation
- States: `ACCEPT`, `INIT`, `LOAD`, `ROUND`, `FIN_LOAD`, `FIN_ROUND`, `DONE`, `ERR`.
- `ACCEPT`: `in_ready`=1. On handshake, latch `in_data` into `byte_q` and `in_last` into `last_q`.
  - Next state is `INIT` if `first_q`=1, else `LOAD`.
- `INIT`: `start`=1 for one cycle. Clears `len_q` (64-bit byte count) and `first_q`. Next state `LOAD`.
- `LOAD`:
  - If `case_R_c_zero`=0, go to `ERR`.
  - Otherwise `validate_input`=1, `B`=`byte_q`, `len_q`+=1 (wraps mod 2^64; unreachable before `ERR`). Next state `ROUND`.
- `ROUND`: `validate_R_h`=1, `R_i`=`rnd_q`, `B`=`byte_q`; `rnd_q` counts 0..N_ROUNDS-1.
  - At the last round: if `last_q`, go to `FIN_LOAD` with `fin_q`=0; else go to `ACCEPT`.
- `FIN_LOAD`: `switch_operation`=1, `validate_input`=1, `B`=`len_q[8*fin_q +: 8]`. Next state `FIN_ROUND`.
- `FIN_ROUND`: same as `ROUND` with `switch_operation`=1.
  - After the last round, `fin_q`++. Go to `DONE` if `fin_q`=LEN_BYTES-1, else `FIN_LOAD`.
- `DONE`: `digest`<=`digest_in`, `digest_valid`<=1 (registered, visible next cycle). Set `first_q`=1. Next state `ACCEPT`.
- `ERR`: `err`=1, `in_ready`=0, no datapath strobes. Left only by `rst`.
- Strobes not named for a state are 0. `B`=0 in `ACCEPT`, `INIT`, `DONE`, `ERR`.
- Empty messages are not supported: a message is always at least one byte carrying `in_last`.

## Timing
- Reset values:
  - State `ACCEPT`, `first_q`=1.
  - All strobes 0, `B`=0, `R_i`=0.
  - `digest`=0, `digest_valid`=0, `err`=0, `len_q`=0.
  - `in_ready`=1 from the first cycle after reset.
- Byte throughput:
  - Handshake at cycle t, `LOAD` at t+1 (t+2 for the first byte), rounds t+2..t+9.
  - `in_ready` returns at t+10, i.e. one byte per 10 cycles.
- Finalization takes LEN_BYTES×(1+N_ROUNDS) cycles = 72 at defaults. Then `DONE`, then `digest_valid`.
- `in_ready` is 0 outside `ACCEPT`. `in_valid` without `in_ready` is ignored, with no latching.
- `in_ready` is combinational from state only, never from `in_valid`.
- `digest` holds until the next `DONE` or `rst`. `digest_valid` is exactly one cycle.
- `rst` mid-message aborts immediately to the reset values. No `start` is issued until the next first byte.

## Structure
- Shared package `hes_pkg` holds:
  - `hes_ctrl_state_t` enum.
  - `H_INIT`=32'h3FA1EF23.
  - `N_ROUNDS_DEF`=8, `LEN_BYTES_DEF`=8.
  - `R_I_W`=3.
- Single sub-module `hes_round_counter`: a 3-bit counter with `clr`, `en`, output `idx` and terminal flag `tc` at N_ROUNDS-1.
  - Instantiated twice, for `rnd_q` and `fin_q`.
- Everything else is one FSM with registered outputs decoded from state.

## Test plan
- Reset, then a single byte 0xA5 with `in_last` at cycle 0:
  - `start` at 1; `validate_input` at 2 with B=0xA5; `R_i`=0..7 at 3..10.
  - Finalization B=0x01 at 11, then 0x00 at 20,29,…,74.
  - `digest_valid` at 84 equal to `digest_in` sampled at 83.
- Three bytes 0x00,0xFF,0x3C presented back-to-back:
  - Handshakes at cycles 0, 11 and 21; `in_ready` low in between.
  - Finalization first byte B=0x03.
- Two consecutive messages: `start` fires again for the second message's first byte. The second message's finalization length restarts at 1.
- `in_valid` asserted during `ROUND`: no handshake and `byte_q` unchanged. The byte is taken on the first `ACCEPT` cycle.
- `case_R_c_zero` forced 0 at `LOAD`: `ERR`, `err`=1 and `in_ready`=0 held. `rst` clears to reset values.
- `rst` pulsed during `FIN_ROUND` (cycle 40 of a one-byte message): all outputs reset next cycle, no `digest_valid`. A new message then issues `start`.
